// File: rtl/order_packetizer.sv
// Multi-lane order packetizer: round-robin arbitration, then a two-stage pipeline
// that stamps each order with a header, a per-lane sequence number and an XOR checksum.
module order_packetizer #(
  parameter int          NUM_CH   = 4,
  parameter int          ORDER_W  = 64,
  parameter int          SEQ_W    = 32,
  parameter logic [7:0]  MSG_TYPE = 8'hA5,
  parameter int          OUT_W    = 32 + SEQ_W + ORDER_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*ORDER_W-1:0] in_order,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic                      seq_clear,
  output logic [OUT_W-1:0]          out_frame,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BODY_W    = OUT_W - 16;
  localparam int NUM_WORDS = BODY_W / 16;

  logic [ORDER_W-1:0] order_a;
  logic [CH_W-1:0]    ch_a;
  logic               valid_a;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant;
  logic               found;
  logic               advance_b;
  logic               accept_a;
  logic               take;
  logic               load_b;
  logic [SEQ_W-1:0]   seq_cnt [NUM_CH];
  logic [SEQ_W-1:0]   seq_cur;
  logic [BODY_W-1:0]  body;
  logic [15:0]        csum;

  assign advance_b = !out_valid || out_ready;
  assign accept_a  = !valid_a || advance_b;
  assign take      = found && accept_a && !reset;
  assign load_b    = advance_b && valid_a;
  assign seq_cur   = seq_cnt[ch_a];

  // First valid lane at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin : arbiter
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && in_valid[idx]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) in_ready = NUM_CH'(1) << grant;
  end

  always_comb begin
    body = {MSG_TYPE, 8'(ch_a), seq_cur, order_a};
    csum = '0;
    for (int w = 0; w < NUM_WORDS; w++) csum = csum ^ body[w*16 +: 16];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_a <= 1'b0;
      order_a <= '0;
      ch_a    <= '0;
      rr_ptr  <= '0;
    end else if (accept_a) begin
      valid_a <= take;
      if (take) begin
        order_a <= in_order[int'(grant)*ORDER_W +: ORDER_W];
        ch_a    <= grant;
        rr_ptr  <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // A load in the same cycle as seq_clear still uses the pre-clear count; the counter lands at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_frame <= '0;
      for (int i = 0; i < NUM_CH; i++) seq_cnt[i] <= '0;
    end else begin
      if (advance_b) begin
        out_valid <= valid_a;
        if (valid_a) out_frame <= {body, csum};
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (seq_clear)                          seq_cnt[i] <= '0;
        else if (load_b && ch_a == CH_W'(i))    seq_cnt[i] <= seq_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_order_packetizer.sv
// Directed bench for order_packetizer (SEQ_W=16 so sequence wrap is reachable).
module tb_order_packetizer;

  localparam int NUM_CH  = 4;
  localparam int ORDER_W = 64;
  localparam int SEQ_W   = 16;
  localparam int OUT_W   = 32 + SEQ_W + ORDER_W;
  localparam int WRAP_N  = 65538;

  logic                      clk;
  logic                      reset;
  logic [NUM_CH*ORDER_W-1:0] in_order;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic                      seq_clear;
  logic [OUT_W-1:0]          out_frame;
  logic                      out_valid;
  logic                      out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  order_packetizer #(
    .NUM_CH(NUM_CH), .ORDER_W(ORDER_W), .SEQ_W(SEQ_W), .MSG_TYPE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .in_order(in_order), .in_valid(in_valid),
    .in_ready(in_ready), .seq_clear(seq_clear), .out_frame(out_frame),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] make_frame(input int ch, input logic [15:0] seq,
                                                  input logic [63:0] ord);
    logic [95:0] b;
    logic [15:0] c;
    b = {8'hA5, 8'(ch), seq, ord};
    c = '0;
    for (int w = 0; w < 6; w++) c = c ^ b[w*16 +: 16];
    return {b, c};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'hF;
    in_order  = '0;
    seq_clear = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_out_valid", 128'(out_valid), 128'(0));
    check_output("rst_in_ready", 128'(in_ready), 128'(0));
    check_output("rst_out_frame", 128'(out_frame), 128'(0));
    @(negedge clk);
    reset    = 1'b0;
    in_valid = '0;

    // Single order on lane 2; checksum A502 worked out by hand.
    @(negedge clk);
    in_valid = 4'b0100;
    in_order[2*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    #1;
    check_output("single_in_ready", 128'(in_ready), 128'(4'b0100));
    @(negedge clk);
    in_valid = '0;
    #1;
    check_output("single_lat_a", 128'(out_valid), 128'(0));
    @(negedge clk);
    #1;
    check_output("single_valid", 128'(out_valid), 128'(1));
    check_output("single_frame", 128'(out_frame),
                 128'(112'hA502_0000_0123_4567_89AB_CDEF_A502));
    @(negedge clk);
    #1;
    check_output("single_one_cycle", 128'(out_valid), 128'(0));

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // All four lanes valid: grants 0,1,2,3,... and per-lane seq 0,1,2.
    for (int i = 0; i < NUM_CH; i++) in_order[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      in_valid = (k < 12) ? 4'hF : 4'h0;
      #1;
      if (k < 12) check_output($sformatf("rr_grant_%0d", k), 128'(in_ready), 128'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        check_output($sformatf("rr_valid_%0d", k), 128'(out_valid), 128'(1));
        check_output($sformatf("rr_frame_%0d", k), 128'(out_frame),
                     128'(make_frame((k-2) % 4, 16'((k-2) / 4),
                                     64'hC0DE_0000_0000_0000 | 64'((k-2) % 4))));
      end
    end
    @(negedge clk);
    in_valid = '0;
    #1;
    check_output("rr_drained", 128'(out_valid), 128'(0));

    // Backpressure: out_ready low for 5 cycles with lanes 0 and 1 valid.
    in_order[0 +: 64]  = 64'hAAAA_0000_0000_0001;
    in_order[64 +: 64] = 64'hBBBB_0000_0000_0002;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j < 5) begin
        out_ready = 1'b0;
        in_valid  = 4'b0011;
      end else begin
        out_ready = 1'b1;
        in_valid  = 4'b0000;
      end
      #1;
      case (j)
        0: check_output("bp_grant0", 128'(in_ready), 128'(4'b0001));
        1: begin
          check_output("bp_grant1", 128'(in_ready), 128'(4'b0010));
          check_output("bp_lat", 128'(out_valid), 128'(0));
        end
        2, 3, 4: begin
          check_output($sformatf("bp_stall_ready_%0d", j), 128'(in_ready), 128'(0));
          check_output($sformatf("bp_hold_valid_%0d", j), 128'(out_valid), 128'(1));
          check_output($sformatf("bp_hold_frame_%0d", j), 128'(out_frame),
                       128'(make_frame(0, 16'd3, 64'hAAAA_0000_0000_0001)));
        end
        5: begin
          check_output("bp_rel0_valid", 128'(out_valid), 128'(1));
          check_output("bp_rel0_frame", 128'(out_frame),
                       128'(make_frame(0, 16'd3, 64'hAAAA_0000_0000_0001)));
        end
        6: begin
          check_output("bp_rel1_valid", 128'(out_valid), 128'(1));
          check_output("bp_rel1_frame", 128'(out_frame),
                       128'(make_frame(1, 16'd3, 64'hBBBB_0000_0000_0002)));
        end
        default: check_output("bp_no_dup", 128'(out_valid), 128'(0));
      endcase
    end

    // seq_clear coincident with a stage-B load on lane 2 (count 3 before the clear).
    @(negedge clk);
    in_valid = 4'b0100;
    in_order[2*64 +: 64] = 64'h1111_2222_3333_4444;
    #1;
    check_output("clr_grant0", 128'(in_ready), 128'(4'b0100));
    @(negedge clk);
    in_order[2*64 +: 64] = 64'h5555_6666_7777_8888;
    seq_clear = 1'b1;
    #1;
    check_output("clr_grant1", 128'(in_ready), 128'(4'b0100));
    @(negedge clk);
    in_valid  = '0;
    seq_clear = 1'b0;
    #1;
    check_output("clr_pre_frame", 128'(out_frame),
                 128'(make_frame(2, 16'd3, 64'h1111_2222_3333_4444)));
    @(negedge clk);
    #1;
    check_output("clr_post_frame", 128'(out_frame),
                 128'(make_frame(2, 16'd0, 64'h5555_6666_7777_8888)));
    @(negedge clk);
    #1;
    check_output("clr_drained", 128'(out_valid), 128'(0));

    // Reset with both stages full, then check pointer and counters restart.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    in_order[0 +: 64]  = 64'hDEAD_0000_0000_0000;
    in_order[64 +: 64] = 64'hDEAD_0000_0000_0001;
    #1;
    check_output("mid_grant0", 128'(in_ready), 128'(4'b0001));
    @(negedge clk);
    #1;
    check_output("mid_grant1", 128'(in_ready), 128'(4'b0010));
    @(negedge clk);
    #1;
    check_output("mid_full_valid", 128'(out_valid), 128'(1));
    check_output("mid_full_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;
    #1;
    check_output("mid_rst_valid", 128'(out_valid), 128'(0));
    check_output("mid_rst_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0110;
    in_order[64 +: 64]   = 64'hBEEF_0000_0000_0001;
    in_order[2*64 +: 64] = 64'hBEEF_0000_0000_0002;
    #1;
    check_output("post_rst_grant1", 128'(in_ready), 128'(4'b0010));
    @(negedge clk);
    #1;
    check_output("post_rst_grant2", 128'(in_ready), 128'(4'b0100));
    check_output("post_rst_no_replay", 128'(out_valid), 128'(0));
    @(negedge clk);
    in_valid = '0;
    #1;
    check_output("post_rst_frame1", 128'(out_frame),
                 128'(make_frame(1, 16'd0, 64'hBEEF_0000_0000_0001)));
    @(negedge clk);
    #1;
    check_output("post_rst_frame2", 128'(out_frame),
                 128'(make_frame(2, 16'd0, 64'hBEEF_0000_0000_0002)));

    // Lane 0 continuously valid across the 16-bit sequence wrap.
    for (int k = 0; k < WRAP_N + 2; k++) begin
      @(negedge clk);
      if (k < WRAP_N) begin
        in_valid = 4'b0001;
        in_order[0 +: 64] = 64'(k);
      end else begin
        in_valid = '0;
      end
      #1;
      if (k == 0 || k == WRAP_N - 1)
        check_output($sformatf("wrap_grant_%0d", k), 128'(in_ready), 128'(4'b0001));
      if (k >= 2) begin
        check_output($sformatf("wrap_valid_%0d", k), 128'(out_valid), 128'(1));
        if (k - 2 >= 65534)
          check_output($sformatf("wrap_frame_%0d", k - 2), 128'(out_frame),
                       128'(make_frame(0, 16'(k - 2), 64'(k - 2))));
      end
    end
    @(negedge clk);
    #1;
    check_output("wrap_drained", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
